// File: rtl/sig_link_arbiter.sv
// sig_link_arbiter: round-robin arbiter with bounded bursts sharing one registered output slot
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   req_valid    per-producer valid
//   req_data     producer values, producer i at [i*DATA_W +: DATA_W]
//   req_ready    per-producer accept strobe, one-hot or zero
//   out_valid    output slot holds a beat
//   out_data     beat value to the consumer
//   out_src      producer index that sourced the beat
//   out_ready    consumer accepts the beat
//   busy         slot occupied or a burst is in progress
module sig_link_arbiter #(
    parameter int N_REQ = 4,
    parameter int DATA_W = 3,
    parameter int BURST_MAX = 2,
    localparam int SRC_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
    input  logic                    out_ready,
    output logic                    busy
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nx;
    logic [SRC_W-1:0] rr_ptr, rr_nx, owner, owner_nx, winner, cand, gidx;
    logic [CNT_W-1:0] burst_cnt, cnt_nx;
    logic found, can_load, accept;
    assign can_load = !out_valid || out_ready;
    // candidate index is reduced mod N_REQ so non-power-of-two sizes stay in range
    always_comb begin
        found = 1'b0;
        winner = '0;
        cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = SRC_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                winner = cand;
            end
        end
    end
    always_comb begin
        state_nx = state;
        rr_nx = rr_ptr;
        owner_nx = owner;
        cnt_nx = burst_cnt;
        accept = 1'b0;
        gidx = owner;
        if (can_load) begin
            if (state == IDLE) begin
                if (found) begin
                    accept = 1'b1;
                    gidx = winner;
                    rr_nx = (winner == SRC_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    if (BURST_MAX > 1) begin
                        state_nx = LOCKED;
                        owner_nx = winner;
                        cnt_nx = CNT_W'(1);
                    end
                end
            end else if (req_valid[owner]) begin
                accept = 1'b1;
                cnt_nx = burst_cnt + 1'b1;
                if (cnt_nx == CNT_W'(BURST_MAX)) begin
                    state_nx = IDLE;
                    cnt_nx = '0;
                end
            end else begin
                // owner went quiet: release the link, costing one bubble
                state_nx = IDLE;
                cnt_nx = '0;
            end
        end
    end
    assign req_ready = (rst_n && accept) ? N_REQ'(1) << gidx : '0;
    assign busy = out_valid || state == LOCKED;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            owner <= '0;
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_src <= '0;
        end else begin
            state <= state_nx;
            rr_ptr <= rr_nx;
            owner <= owner_nx;
            burst_cnt <= cnt_nx;
            if (accept) begin
                out_valid <= 1'b1;
                out_data <= req_data[gidx*DATA_W +: DATA_W];
                out_src <= gidx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sig_link_arbiter.sv
// tb_sig_link_arbiter: directed and randomized checks of sig_link_arbiter against a behavioural model
module tb_sig_link_arbiter;
    localparam int N = 4;
    localparam int DW = 3;
    localparam int BM = 2;
    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0] req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0] req_ready;
    logic out_valid;
    logic [DW-1:0] out_data;
    logic [1:0] out_src;
    logic out_ready;
    logic busy;
    int checks, failures;
    int g;
    bit m_lock, m_ov;
    int m_owner, m_cnt, m_ptr, m_od, m_os;
    int fair[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [DW-1:0] hold_d;
    logic [1:0] hold_s;

    sig_link_arbiter #(.N_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_ov = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_od = 0; m_os = 0;
    endtask

    function automatic int exp_grant();
        if (m_ov && !out_ready) return -1;
        if (m_lock) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // called at posedge+1 with inputs already driven; checks just before the falling edge
    task automatic settle();
        #3;
        g = exp_grant();
        chk("req_ready", req_ready, g >= 0 ? (32'd1 << g) : 32'd0);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_src", out_src, m_os);
        chk("busy", busy, m_ov || m_lock);
    endtask

    task automatic advance();
        bit cl;
        cl = !m_ov || out_ready;
        if (m_lock) begin
            if (cl) begin
                if (g >= 0) begin
                    m_cnt++;
                    if (m_cnt == BM) m_lock = 0;
                end else m_lock = 0;
            end
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (BM > 1) begin m_lock = 1; m_owner = g; m_cnt = 1; end
        end
        if (g >= 0) begin
            m_ov = 1; m_od = int'(req_data[g*DW +: DW]); m_os = g;
        end else if (out_ready) m_ov = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        req_valid = N'($urandom);
        req_data = (N*DW)'($urandom);
        out_ready = 1'($urandom);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic rnd_drive();
        for (int i = 0; i < N; i++)
            if (!req_valid[i] || g == i) begin
                req_valid[i] = 1'($urandom_range(0, 1));
                req_data[i*DW +: DW] = DW'($urandom);
            end
        out_ready = $urandom_range(0, 3) != 0;
    endtask

    initial begin
        checks = 0; failures = 0; g = -1;
        rst_n = 0; req_valid = '0; req_data = '0; out_ready = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        req_valid = 4'b1010; out_ready = 1;
        settle();
        chk("first_grant_lowest", req_ready, 4'b0010);
        advance();

        do_reset();
        req_valid = 4'b0100; req_data = 12'o0500; out_ready = 1;
        settle();
        chk("single_ready", req_ready, 4'b0100);
        advance();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 5);
        chk("single_src", out_src, 2);

        do_reset();
        req_valid = 4'b1111; out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            settle();
            advance();
            chk("fair_src", out_src, fair[i]);
            chk("fair_no_bubble", out_valid, 1);
            req_data[g*DW +: DW] = DW'($urandom);
        end

        out_ready = 0;
        hold_d = out_data;
        hold_s = out_src;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_ready", req_ready, 0);
            advance();
            chk("bp_data", out_data, hold_d);
            chk("bp_src", out_src, hold_s);
            chk("bp_valid", out_valid, 1);
        end
        out_ready = 1;
        settle();
        chk("bp_reload_ready", req_ready, 4'b0010);
        advance();
        chk("bp_reload_valid", out_valid, 1);
        chk("bp_reload_src", out_src, 1);

        do_reset();
        req_valid = 4'b0011; out_ready = 1;
        settle();
        chk("drop_first", req_ready, 4'b0001);
        advance();
        req_valid = 4'b0010;
        settle();
        chk("drop_bubble", req_ready, 4'b0000);
        advance();
        chk("drop_drained", out_valid, 0);
        settle();
        chk("drop_next", req_ready, 4'b0010);
        advance();
        chk("drop_src", out_src, 1);

        do_reset();
        req_valid = 4'b1111; out_ready = 1;
        settle();
        advance();
        chk("async_pre_busy", busy, 1);
        chk("async_pre_valid", out_valid, 1);
        #1;
        rst_n = 0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out_data", out_data, 0);
        chk("async_out_src", out_src, 0);
        chk("async_busy", busy, 0);
        chk("async_req_ready", req_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        settle();
        chk("async_restart", req_ready, 4'b0001);
        advance();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            settle();
            advance();
            rnd_drive();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sig_link_arbiter.md
Name: sig_link_arbiter

Overview:
Round-robin arbiter that shares one consumer-side signal link between N_REQ producer ports. It lets a winning producer hold the link for a bounded burst of beats. Each producer presents a DATA_W-bit value with valid/ready. The arbiter registers the winning beat into a single output slot that drives the consumer, and tags the beat with its source index. It sits in the aggregator between producer instances and a single consumer instance.

Parameters:
N_REQ, 4, number of producer ports; must be ≥2.
DATA_W, 3, width of each producer value and of out_data.
BURST_MAX, 2, maximum consecutive beats granted to one owner before re-arbitration; must be ≥1.
SRC_W, $clog2(N_REQ), width of out_src; derived, not overridden.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  N_REQ  per-producer valid.
req_data  input  N_REQ*DATA_W  producer values; producer i occupies bits [i*DATA_W +: DATA_W].
req_ready  output  N_REQ  per-producer accept strobe; at most one bit set per cycle.
out_valid  output  1  output slot holds a beat.
out_data  output  DATA_W  beat value to consumer.
out_src  output  SRC_W  index of the producer that sourced the beat.
out_ready  input  1  consumer accepts the beat.
busy  output  1  out_valid OR state==LOCKED.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - out_valid=0, out_data=0, out_src=0.
  - state=IDLE, rr_ptr=0, burst_cnt=0, owner=0.
  - req_ready=0 and busy=0 combinationally while in reset.
- Handshake protocol:
  - Producer i transfers when req_valid[i] && req_ready[i].
  - Producers hold valid and data stable until accepted.
  - req_ready may depend combinationally on req_valid.
  - Consumer transfers when out_valid && out_ready.
  - Output slot holds out_data and out_src stable until that transfer.
- can_load = !out_valid || out_ready. The slot may drain and reload in the same cycle, giving 1 beat/cycle throughput.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1.
- IDLE:
  - winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … mod N_REQ.
  - If any valid && can_load: req_ready[winner]=1, load out_data/out_src, out_valid=1.
  - rr_ptr ← (winner+1) mod N_REQ.
  - If BURST_MAX>1: owner ← winner, burst_cnt ← 1, go LOCKED. Otherwise stay IDLE.
  - If no valid: no action. out_valid clears if drained.
- LOCKED:
  - Only owner is eligible; all other req_ready bits are 0.
  - If req_valid[owner] && can_load: accept the beat and burst_cnt++. If the new burst_cnt==BURST_MAX, go IDLE.
  - If !req_valid[owner] && can_load: go IDLE with no acceptance this cycle (one bubble).
  - If !can_load: hold state; req_ready=0.
- rr_ptr advances only in IDLE on acceptance, so the post-burst search starts at owner+1.
- Wrap-around: rr_ptr and the winner scan wrap mod N_REQ. N_REQ that is not a power of two must never produce an out-of-range index.
- Simultaneous events: drain plus new accept in the same cycle means out_valid stays 1 and out_* take the new beat.
- Reset mid-operation: a beat in the slot is discarded, a burst is abandoned, and the producer's pending beat is not accepted.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_data=0, out_src=0, req_ready=0, busy=0. After release, the first grant goes to the lowest valid index.
- Single requester: req_valid=4'b0100, req_data[2]=3'b101, out_ready=1 -> req_ready=4'b0100 in cycle t; out_valid=1, out_data=5, out_src=2 in t+1.
- Fairness with bursts (BURST_MAX=2): all four valid continuously, out_ready=1 -> out_src sequence 0,0,1,1,2,2,3,3,0,0. One beat per cycle, no bubbles.
- Backpressure: out_valid=1 and out_ready=0 for 3 cycles -> out_data/out_src stable, req_ready=0 throughout. On the cycle out_ready=1, drain plus reload occurs with out_valid staying 1.
- Owner drops mid-burst: req0 sends one beat then deasserts, req1 valid -> one bubble cycle with req_ready=0, then req_ready[1]=1 and out_src=1.
- Async reset mid-burst: assert rst_n=0 while LOCKED with out_valid=1 -> outputs clear without a clock edge. After release, arbitration restarts from index 0.
